// File: rtl/fastchip_arb_pkg.sv
// rtl/fastchip_arb_pkg.sv - shared types and constants for the fast-chip bus arbiter
package fastchip_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      GAP    = 2'd2
   } state_e;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_AUX = 1'b1
   } grant_e;

   localparam logic [15:0] ERR_READ_DATA = 16'hFFFF;
   localparam int          TO_W          = 16;

   // Saturating increment for the timeout counter; never wraps back to zero.
   function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
      return (&v) ? v : v + TO_W'(1);
   endfunction

endpackage

// File: rtl/fastchip_arb_rr.sv
// rtl/fastchip_arb_rr.sv - 2-way round-robin grant with last_grant register
module fastchip_arb_rr
   import fastchip_arb_pkg::*;
(
   input  logic   clk_sys,
   input  logic   reset,
   input  logic   req_cpu,
   input  logic   req_aux,
   input  logic   take,
   output logic   gnt_valid,
   output grant_e gnt
);

   grant_e last_grant;

   // Pick a master; on a tie the one not served last wins.
   always_comb begin
      gnt_valid = req_cpu | req_aux;
      gnt       = GNT_CPU;
      if (req_cpu && req_aux) begin
         gnt = (last_grant == GNT_AUX) ? GNT_CPU : GNT_AUX;
      end else if (req_aux) begin
         gnt = GNT_AUX;
      end
   end

   // Remember who was served; AUX after reset so the CPU wins the first tie.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         last_grant <= GNT_AUX;
      end else if (take && gnt_valid) begin
         last_grant <= gnt;
      end
   end

endmodule

// File: rtl/fastchip_arbiter.sv
// rtl/fastchip_arbiter.sv - CPU/aux arbiter and sequencer for the fast-chip register bus (option FASTCHIP_ARB_STATS_EN)
module fastchip_arbiter
   import fastchip_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int GAP_CYCLES     = 1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [23:0] cpu_addr,
   input  logic [15:0] cpu_din,
   input  logic        cpu_rnw,
   input  logic        cpu_uds,
   input  logic        cpu_lds,
   input  logic        cpu_longword,
   output logic        cpu_ack,
   output logic [15:0] cpu_dout,
   output logic        cpu_err,
   input  logic        aux_req,
   input  logic [23:0] aux_addr,
   input  logic [15:0] aux_din,
   input  logic        aux_rnw,
   input  logic        aux_uds,
   input  logic        aux_lds,
   input  logic        aux_longword,
   output logic        aux_ack,
   output logic [15:0] aux_dout,
   output logic        aux_err,
   output logic        fc_sel,
   output logic [23:0] fc_addr,
   output logic [15:0] fc_din,
   output logic        fc_rnw,
   output logic        fc_uds,
   output logic        fc_lds,
   output logic        fc_longword,
   input  logic        fc_ready,
   input  logic [15:0] fc_dout,
   output logic        busy
`ifdef FASTCHIP_ARB_STATS_EN
   ,
   input  logic        stat_clr,
   output logic [15:0] stat_timeouts,
   output logic [7:0]  stat_cpu_wait_max
`endif
);

   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]      GAP_LAST = 3'(GAP_CYCLES - 1);

   state_e          state;
   state_e          state_nxt;
   grant_e          gnt;
   grant_e          cur;
   logic            gnt_valid;
   logic            take;
   logic            done_ok;
   logic            done_to;
   logic            done;
   logic [TO_W-1:0] to_cnt;
   logic [2:0]      gap_cnt;

   fastchip_arb_rr u_rr (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .req_cpu   (cpu_req),
      .req_aux   (aux_req),
      .take      (take),
      .gnt_valid (gnt_valid),
      .gnt       (gnt)
   );

   assign done = done_ok | done_to;
   assign busy = (state != IDLE);

   // Next-state and per-cycle strobes; ready beats a same-cycle timeout.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      done_ok   = 1'b0;
      done_to   = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_valid) begin
               take      = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (fc_ready) begin
               done_ok   = 1'b1;
               state_nxt = GAP;
            end else if (to_cnt >= TO_LAST) begin
               done_to   = 1'b1;
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (gap_cnt >= GAP_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Timeout counter runs while waiting for ready and clears outside ACCESS.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (state != ACCESS) begin
         to_cnt <= '0;
      end else if (!fc_ready) begin
         to_cnt <= sat_inc(to_cnt);
      end
   end

   // Idle-gap counter keeps sel low long enough for downstream acks to clear.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         gap_cnt <= '0;
      end else if (state == GAP) begin
         gap_cnt <= gap_cnt + 3'd1;
      end else begin
         gap_cnt <= '0;
      end
   end

   // Latch the winning master's request onto the bus and drop sel on completion.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         fc_sel      <= 1'b0;
         fc_addr     <= '0;
         fc_din      <= '0;
         fc_rnw      <= 1'b1;
         fc_uds      <= 1'b0;
         fc_lds      <= 1'b0;
         fc_longword <= 1'b0;
         cur         <= GNT_CPU;
      end else if (take) begin
         fc_sel <= 1'b1;
         cur    <= gnt;
         if (gnt == GNT_CPU) begin
            fc_addr     <= cpu_addr;
            fc_din      <= cpu_din;
            fc_rnw      <= cpu_rnw;
            fc_uds      <= cpu_uds;
            fc_lds      <= cpu_lds;
            fc_longword <= cpu_longword;
         end else begin
            fc_addr     <= aux_addr;
            fc_din      <= aux_din;
            fc_rnw      <= aux_rnw;
            fc_uds      <= aux_uds;
            fc_lds      <= aux_lds;
            fc_longword <= aux_longword;
         end
      end else if (done) begin
         fc_sel <= 1'b0;
      end
   end

   // Completion pulses and read data back to the granted master only.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cpu_ack  <= 1'b0;
         cpu_err  <= 1'b0;
         cpu_dout <= '0;
         aux_ack  <= 1'b0;
         aux_err  <= 1'b0;
         aux_dout <= '0;
      end else begin
         cpu_ack <= done && (cur == GNT_CPU);
         cpu_err <= done_to && (cur == GNT_CPU);
         aux_ack <= done && (cur == GNT_AUX);
         aux_err <= done_to && (cur == GNT_AUX);
         if (done && fc_rnw && (cur == GNT_CPU)) begin
            cpu_dout <= done_ok ? fc_dout : ERR_READ_DATA;
         end
         if (done && fc_rnw && (cur == GNT_AUX)) begin
            aux_dout <= done_ok ? fc_dout : ERR_READ_DATA;
         end
      end
   end

`ifdef FASTCHIP_ARB_STATS_EN
   logic [7:0] cpu_wait;
   logic [7:0] cpu_wait_fin;

   assign cpu_wait_fin = (&cpu_wait) ? cpu_wait : cpu_wait + 8'd1;

   // Saturating count of timed-out transactions; clear wins over increment.
   always_ff @(posedge clk_sys) begin
      if (reset || stat_clr) begin
         stat_timeouts <= '0;
      end else if (done_to && !(&stat_timeouts)) begin
         stat_timeouts <= stat_timeouts + 16'd1;
      end
   end

   // Track how long the CPU waits for each ack and keep the worst case.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cpu_wait          <= '0;
         stat_cpu_wait_max <= '0;
      end else begin
         if (done && (cur == GNT_CPU)) begin
            cpu_wait <= '0;
         end else if (cpu_req && !cpu_ack && !(&cpu_wait)) begin
            cpu_wait <= cpu_wait + 8'd1;
         end
         if (stat_clr) begin
            stat_cpu_wait_max <= '0;
         end else if (done && (cur == GNT_CPU) && (cpu_wait_fin > stat_cpu_wait_max)) begin
            stat_cpu_wait_max <= cpu_wait_fin;
         end
      end
   end
`endif

endmodule
